// File: rtl/instr_encoder.sv
// Packs symbolic instruction requests into 32-bit MIPS words. Requests are
// buffered in a small FIFO; the head is encoded on pop and held in an output
// register that drives a valid/ready port together with its byte address.
module instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h00003000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_word,
    output logic              err,
    output logic [3:0]        err_op,
    output logic [15:0]       count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 4 + 5 + 5 + 5 + 26;

    // FIFO storage; the output register acts as the registered read stage
    logic [EW-1:0]     mem_reg [DEPTH];
    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic [DEPTH-1:0]  wr_sel;

    logic              out_valid_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic [31:0]       out_word_reg;
    logic              err_reg;
    logic [3:0]        err_op_reg;
    logic [15:0]       count_reg;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              out_fire;

    logic [EW-1:0]     head;
    logic [3:0]        head_op;
    logic [4:0]        head_rs;
    logic [4:0]        head_rt;
    logic [4:0]        head_rd;
    logic [25:0]       head_imm;
    logic [31:0]       head_word;
    logic              head_legal;

    // Pointers carry one extra wrap bit to tell full from empty
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign out_fire = out_valid_reg && out_ready;
    assign pop      = !empty && (!out_valid_reg || out_ready);

    // One-hot write select per FIFO entry
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = push && (wr_ptr_reg[AW-1:0] == AW'(gi));
    end

    // FIFO entry writes (no reset needed on payload storage)
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem_reg[i] <= {in_op, in_rs, in_rt, in_rd, in_imm};
            end
        end
    end

    assign head     = mem_reg[rd_ptr_reg[AW-1:0]];
    assign head_op  = head[44:41];
    assign head_rs  = head[40:36];
    assign head_rt  = head[35:31];
    assign head_rd  = head[30:26];
    assign head_imm = head[25:0];

    // Encode the FIFO head; unused fields of each format are forced to zero
    always_comb begin
        head_word  = 32'h0;
        head_legal = 1'b1;
        case (head_op)
            4'd0: head_word = 32'h0;
            4'd1: head_word = {6'b000000, head_rs, head_rt, head_rd, 5'b00000, 6'b100001};
            4'd2: head_word = {6'b000000, head_rs, head_rt, head_rd, 5'b00000, 6'b100011};
            4'd3: head_word = {6'b001101, head_rs, head_rt, head_imm[15:0]};
            4'd4: head_word = {6'b001111, 5'b00000, head_rt, head_imm[15:0]};
            4'd5: head_word = {6'b100011, head_rs, head_rt, head_imm[15:0]};
            4'd6: head_word = {6'b101011, head_rs, head_rt, head_imm[15:0]};
            4'd7: head_word = {6'b000100, head_rs, head_rt, head_imm[15:0]};
            4'd8: head_word = {6'b000011, head_imm};
            4'd9: head_word = {6'b000000, head_rs, 15'b0, 6'b001000};
            default: head_legal = 1'b0;
        endcase
    end

    // Pointers, output register, address/count tracking and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_addr_reg  <= BASE_ADDR;
            out_word_reg  <= 32'h0;
            err_reg       <= 1'b0;
            err_op_reg    <= 4'd0;
            count_reg     <= 16'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (out_fire) begin
                out_addr_reg <= out_addr_reg + ADDR_W'(4);
                count_reg    <= count_reg + 16'd1;
            end
            if (pop) begin
                if (head_legal) begin
                    out_word_reg  <= head_word;
                    out_valid_reg <= 1'b1;
                end else begin
                    // Dropped request: the slot is empty or was just consumed
                    out_valid_reg <= 1'b0;
                    err_reg       <= 1'b1;
                    if (!err_reg) begin
                        err_op_reg <= head_op;
                    end
                end
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_addr  = out_addr_reg;
    assign out_word  = out_word_reg;
    assign err       = err_reg;
    assign err_op    = err_op_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder with a queue-based model.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [25:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_addr;
    logic [31:0] out_word;
    logic        err;
    logic [3:0]  err_op;
    logic [15:0] count;

    logic        w_in_ready;
    logic        w_out_valid;
    logic [3:0]  w_out_addr;
    logic [31:0] w_out_word;
    logic        w_err;
    logic [3:0]  w_err_op;
    logic [15:0] w_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_word(out_word), .err(err), .err_op(err_op), .count(count)
    );

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(4), .BASE_ADDR(4'hC)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_addr(w_out_addr),
        .out_word(w_out_word), .err(w_err), .err_op(w_err_op), .count(w_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoding built from the field layout with plain arithmetic
    function automatic logic [31:0] model_encode(input int unsigned op, input int unsigned rs,
                                                 input int unsigned rt, input int unsigned rd,
                                                 input int unsigned imm);
        int unsigned i16;
        int unsigned i26;
        i16 = imm % 65536;
        i26 = imm % 67108864;
        case (op)
            1: return (rs << 21) + (rt << 16) + (rd << 11) + 33;
            2: return (rs << 21) + (rt << 16) + (rd << 11) + 35;
            3: return (13 << 26) + (rs << 21) + (rt << 16) + i16;
            4: return (15 << 26) + (rt << 16) + i16;
            5: return (35 << 26) + (rs << 21) + (rt << 16) + i16;
            6: return (43 << 26) + (rs << 21) + (rt << 16) + i16;
            7: return (4 << 26) + (rs << 21) + (rt << 16) + i16;
            8: return (3 << 26) + i26;
            9: return (rs << 21) + 8;
            default: return 32'h0;
        endcase
    endfunction

    // Model state, owned by the monitor
    logic [31:0] exp_q[$];
    logic [31:0] log_word_q[$];
    logic [31:0] log_addr_q[$];
    logic [3:0]  log_waddr_q[$];
    int          emitted = 0;
    logic        err_exp = 1'b0;
    logic [3:0]  err_op_exp = 4'd0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_word = '0;
    logic [31:0] prev_addr = '0;

    // Ready driver: held value or a fresh random value every cycle
    logic rmode = 1'b0;
    logic rval = 1'b1;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rmode ? 1'($urandom_range(0, 1)) : rval;
        end
    end

    // Monitor: sample mid-cycle, check outputs against the model, record pushes
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            log_word_q.delete();
            log_addr_q.delete();
            log_waddr_q.delete();
            emitted    = 0;
            err_exp    = 1'b0;
            err_op_exp = 4'd0;
            stall_prev = 1'b0;
        end else begin
            check("count", 64'(count), 64'(emitted % 65536));
            check("w_count", 64'(w_count), 64'(emitted % 65536));
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_word", 64'(out_word), 64'(prev_word));
                check("hold_addr", 64'(out_addr), 64'(prev_addr));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", 64'(out_valid), 64'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("word", 64'(out_word), 64'(e));
                    check("addr", 64'(out_addr), 64'(32'h3000 + 32'(4 * emitted)));
                    check("w_addr", 64'(w_out_addr), 64'((12 + 4 * emitted) % 16));
                    check("w_word", 64'(w_out_word), 64'(e));
                    $display("emit #%0d addr=%08h waddr=%h word=%08h", emitted, out_addr, w_out_addr, out_word);
                    log_word_q.push_back(out_word);
                    log_addr_q.push_back(out_addr);
                    log_waddr_q.push_back(w_out_addr);
                    emitted++;
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_word  = out_word;
            prev_addr  = out_addr;
            if (in_valid && in_ready) begin
                if (in_op <= 4'd9) begin
                    exp_q.push_back(model_encode(in_op, in_rs, in_rt, in_rd, in_imm));
                end else if (!err_exp) begin
                    err_exp    = 1'b1;
                    err_op_exp = in_op;
                end
            end
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Present one request and hold it until accepted (entered at posedge+1)
    task automatic push(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [25:0] imm);
        int n;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n >= 200) begin
                check("push_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("drain_timeout", 64'(n), 64'd0);
        repeat (DEPTH + 3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'h3000);
        check("rst_out_word", 64'(out_word), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_op", 64'(err_op), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_w_addr", 64'(w_out_addr), 64'hC);
        @(posedge clk);
        #1;

        // ADDU latency
        rval = 1'b1;
        @(posedge clk);
        #1;
        push(4'd1, 5'd1, 5'd2, 5'd3, 26'h3FFFFFF);
        check("lat_early_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_word", 64'(out_word), 64'h00221821);
        check("lat_addr", 64'(out_addr), 64'h3000);
        @(posedge clk);
        #1;
        check("lat_count", 64'(count), 64'd1);
        drain();

        // ORI / LUI / JAL
        do_reset();
        push(4'd3, 5'd0, 5'd8, 5'd31, 26'h0001234);
        push(4'd4, 5'd7, 5'd9, 5'd5, 26'h000FFFF);
        push(4'd8, 5'd3, 5'd4, 5'd6, 26'h0000C00);
        drain();
        check("imm_n", 64'(log_word_q.size()), 64'd3);
        check("ori_word", 64'(log_word_q[0]), 64'h34081234);
        check("lui_word", 64'(log_word_q[1]), 64'h3C09FFFF);
        check("jal_word", 64'(log_word_q[2]), 64'h0C000C00);
        check("imm_addr0", 64'(log_addr_q[0]), 64'h3000);
        check("imm_addr2", 64'(log_addr_q[2]), 64'h3008);
        check("wrap_addr0", 64'(log_waddr_q[0]), 64'hC);
        check("wrap_addr1", 64'(log_waddr_q[1]), 64'h0);

        // Backpressure: DEPTH in FIFO plus one in the output register
        do_reset();
        rval = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        acc = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            in_op = 4'd2; in_rs = 5'(i); in_rt = 5'(i + 1); in_rd = 5'(i + 2); in_imm = '0;
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'(DEPTH + 1));
        check("bp_in_ready", 64'(in_ready), 64'd0);
        rval = 1'b1;
        drain();
        check("bp_count", 64'(count), 64'(DEPTH + 1));

        // Illegal ops
        do_reset();
        push(4'd0, 5'd1, 5'd1, 5'd1, 26'h1);
        push(4'd12, 5'd1, 5'd1, 5'd1, 26'h1);
        push(4'd0, 5'd2, 5'd2, 5'd2, 26'h2);
        drain();
        check("ill_err", 64'(err), 64'd1);
        check("ill_err_op", 64'(err_op), 64'd12);
        check("ill_count", 64'(count), 64'd2);
        check("ill_addr1", 64'(log_addr_q[1]), 64'h3004);
        push(4'd15, 5'd0, 5'd0, 5'd0, 26'h0);
        push(4'd0, 5'd0, 5'd0, 5'd0, 26'h0);
        drain();
        check("ill_err_op_kept", 64'(err_op), 64'd12);
        check("ill_count2", 64'(count), 64'd3);

        // Reset with words buffered
        do_reset();
        rval = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push(4'd1, 5'd4, 5'd5, 5'd6, 26'h0);
        push(4'd5, 5'd4, 5'd5, 5'd6, 26'h10);
        push(4'd6, 5'd4, 5'd5, 5'd6, 26'h20);
        do_reset();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_count", 64'(count), 64'd0);
        rval = 1'b1;
        @(posedge clk);
        #1;
        push(4'd7, 5'd1, 5'd2, 5'd0, 26'hFFFC);
        drain();
        check("mid_rst_n", 64'(log_word_q.size()), 64'd1);
        check("mid_rst_addr", 64'(log_addr_q[0]), 64'h3000);

        // Randomized traffic with random backpressure
        do_reset();
        rmode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            push(op, 5'($urandom), 5'($urandom), 5'($urandom), 26'($urandom));
        end
        rmode = 1'b0;
        rval = 1'b1;
        drain();
        check("rnd_err", 64'(err), 64'(err_exp));
        check("rnd_err_op", 64'(err_op), 64'(err_op_exp));
        check("rnd_w_err", 64'(w_err), 64'(err_exp));
        check("rnd_w_err_op", 64'(w_err_op), 64'(err_op_exp));
        check("rnd_count", 64'(count), 64'(emitted % 65536));
        check("rnd_in_ready", 64'({w_in_ready, in_ready, w_out_valid}), 64'b110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
